// File: rtl/sfx_pkg.sv
// Shared types, event indices and default note patterns for the sound-effect sequencer.
package sfx_pkg;

    localparam int PAT_IDX_W = 3;

    localparam logic [2:0] EV_WIN   = 3'd0;
    localparam logic [2:0] EV_LOSE  = 3'd1;
    localparam logic [2:0] EV_HIT   = 3'd2;
    localparam logic [2:0] EV_MISS  = 3'd3;
    localparam logic [2:0] EV_CLICK = 3'd4;

    typedef struct packed {
        logic [5:0] note;
        logic [5:0] dur;
    } step_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Steps past a pattern's length return dur = 0, which the sequencer treats as end-of-pattern.
    function automatic step_t pattern_step(input logic [2:0] ev, input logic [2:0] idx);
        step_t rec;
        rec = '{note: 6'd0, dur: 6'd0};
        case (ev)
            EV_WIN: begin
                case (idx)
                    3'd0, 3'd1: rec = '{note: 6'd10, dur: 6'd60};
                    3'd2, 3'd3: rec = '{note: 6'd11, dur: 6'd60};
                    3'd4, 3'd5: rec = '{note: 6'd12, dur: 6'd60};
                    default:    rec = '{note: 6'd0,  dur: 6'd0};
                endcase
            end
            EV_LOSE: begin
                case (idx)
                    3'd0, 3'd1: rec = '{note: 6'd12, dur: 6'd60};
                    3'd2, 3'd3: rec = '{note: 6'd11, dur: 6'd60};
                    3'd4, 3'd5: rec = '{note: 6'd10, dur: 6'd60};
                    default:    rec = '{note: 6'd0,  dur: 6'd0};
                endcase
            end
            EV_HIT: begin
                case (idx)
                    3'd0:    rec = '{note: 6'd1, dur: 6'd30};
                    3'd1:    rec = '{note: 6'd2, dur: 6'd30};
                    3'd2:    rec = '{note: 6'd3, dur: 6'd30};
                    3'd3:    rec = '{note: 6'd4, dur: 6'd30};
                    3'd4:    rec = '{note: 6'd5, dur: 6'd30};
                    3'd5:    rec = '{note: 6'd6, dur: 6'd30};
                    default: rec = '{note: 6'd0, dur: 6'd0};
                endcase
            end
            EV_MISS: begin
                case (idx)
                    3'd0:    rec = '{note: 6'd6, dur: 6'd30};
                    3'd1:    rec = '{note: 6'd5, dur: 6'd30};
                    3'd2:    rec = '{note: 6'd4, dur: 6'd30};
                    3'd3:    rec = '{note: 6'd3, dur: 6'd30};
                    3'd4:    rec = '{note: 6'd2, dur: 6'd30};
                    3'd5:    rec = '{note: 6'd1, dur: 6'd30};
                    default: rec = '{note: 6'd0, dur: 6'd0};
                endcase
            end
            EV_CLICK: begin
                case (idx)
                    3'd0:    rec = '{note: 6'd2, dur: 6'd20};
                    3'd1:    rec = '{note: 6'd1, dur: 6'd20};
                    3'd2:    rec = '{note: 6'd3, dur: 6'd20};
                    default: rec = '{note: 6'd0, dur: 6'd0};
                endcase
            end
            default: rec = '{note: 6'd0, dur: 6'd0};
        endcase
        return rec;
    endfunction

endpackage

// File: rtl/sfx_pattern_rom.sv
// Combinational pattern lookup: (effect id, step index) -> {note, dur}.
module sfx_pattern_rom
    import sfx_pkg::*;
#(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int ID_W   = 3,
    parameter int STEP_W = 3
) (
    input  logic [ID_W-1:0]   ev_id,
    input  logic [STEP_W-1:0] step_idx,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  dur
);

    step_t rec_s;

    // Table lookup for one step of one effect.
    always_comb begin
        rec_s = pattern_step(PAT_IDX_W'(ev_id), PAT_IDX_W'(step_idx));
    end

    assign note = NOTE_W'(rec_s.note);
    assign dur  = DUR_W'(rec_s.dur);

endmodule

// File: rtl/sfx_sequencer.sv
// Multi-event sound-effect sequencer: fixed-priority arbitration with preemption,
// pending latches, tick prescaler and per-step note playback.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6,
    parameter int MAX_STEPS = 8,
    parameter int N_EVENTS  = 5,
    parameter int TICK_DIV  = 131072
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [N_EVENTS-1:0]         ev_strobe,
    output logic [NOTE_W-1:0]           note,
    output logic                        busy,
    output logic [$clog2(N_EVENTS)-1:0] active_id,
    output logic                        done_pulse
);

    localparam int ID_W    = $clog2(N_EVENTS);
    localparam int STEP_W  = $clog2(MAX_STEPS);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(MAX_STEPS - 1);
    localparam logic [N_EVENTS-1:0] ONE_HOT_0  = N_EVENTS'(1'b1);

    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_EVENTS-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_EVENTS - 1; i >= 0; i--) begin
            idx = v[i] ? ID_W'(i) : idx;
        end
        return idx;
    endfunction

    state_t              state_r, state_s;
    logic [N_EVENTS-1:0] pending_r, pending_s;
    logic [PRESC_W-1:0]  presc_r, presc_s;
    logic [DUR_W-1:0]    tick_r, tick_s;
    logic [DUR_W-1:0]    dur_r, dur_s;
    logic [STEP_W-1:0]   step_r, step_s;
    logic [ID_W-1:0]     id_r, id_s;
    logic [NOTE_W-1:0]   note_r, note_s;
    logic                done_r, done_s;
    logic                busy_r;

    logic [N_EVENTS-1:0] req_s;
    logic [ID_W-1:0]     req_id_s, strobe_id_s;
    logic [STEP_W-1:0]   step_nxt_s;
    logic [NOTE_W-1:0]   nxt_note_s, start_note_s;
    logic [DUR_W-1:0]    nxt_dur_s, start_dur_s;
    logic                start_s, preempt_s;

    assign req_s       = pending_r | ev_strobe;
    assign req_id_s    = lowest_idx(req_s);
    assign strobe_id_s = lowest_idx(ev_strobe);
    assign step_nxt_s  = step_r + STEP_W'(1'b1);
    // Pending entries always rank below the playing effect, so any strobe at or above it wins.
    assign preempt_s   = (|ev_strobe) && (strobe_id_s <= id_r);

    sfx_pattern_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ID_W(ID_W), .STEP_W(STEP_W)) u_rom_next (
        .ev_id    (id_r),
        .step_idx (step_nxt_s),
        .note     (nxt_note_s),
        .dur      (nxt_dur_s)
    );

    sfx_pattern_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ID_W(ID_W), .STEP_W(STEP_W)) u_rom_start (
        .ev_id    (req_id_s),
        .step_idx ({STEP_W{1'b0}}),
        .note     (start_note_s),
        .dur      (start_dur_s)
    );

    // Next-state logic: arbitration, prescaler, step advance and completion.
    always_comb begin
        state_s   = state_r;
        pending_s = req_s;
        presc_s   = presc_r;
        tick_s    = tick_r;
        dur_s     = dur_r;
        step_s    = step_r;
        id_s      = id_r;
        note_s    = note_r;
        done_s    = 1'b0;
        start_s   = 1'b0;
        if (!enable) begin
            state_s   = ST_IDLE;
            pending_s = '0;
            presc_s   = '0;
            tick_s    = '0;
            dur_s     = '0;
            step_s    = '0;
            id_s      = '0;
            note_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_s) begin
                        start_s = 1'b1;
                    end else begin
                        note_s = '0;
                        id_s   = '0;
                    end
                end
                ST_PLAY: begin
                    if (preempt_s) begin
                        start_s = 1'b1;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_s = '0;
                        if (tick_r == dur_r - DUR_W'(1'b1)) begin
                            tick_s = '0;
                            if ((step_r == STEP_LAST) || (nxt_dur_s == '0)) begin
                                done_s = 1'b1;
                                if (|req_s) begin
                                    start_s = 1'b1;
                                end else begin
                                    state_s = ST_IDLE;
                                    step_s  = '0;
                                    dur_s   = '0;
                                    id_s    = '0;
                                    note_s  = '0;
                                end
                            end else begin
                                step_s = step_nxt_s;
                                note_s = nxt_note_s;
                                dur_s  = nxt_dur_s;
                            end
                        end else begin
                            tick_s = tick_r + DUR_W'(1'b1);
                        end
                    end else begin
                        presc_s = presc_r + PRESC_W'(1'b1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    note_s  = '0;
                    id_s    = '0;
                end
            endcase
            if (start_s) begin
                state_s   = ST_PLAY;
                id_s      = req_id_s;
                step_s    = '0;
                tick_s    = '0;
                presc_s   = '0;
                note_s    = start_note_s;
                dur_s     = start_dur_s;
                pending_s = req_s & ~(ONE_HOT_0 << req_id_s);
            end else begin
                pending_s = req_s;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
            presc_r   <= '0;
            tick_r    <= '0;
            dur_r     <= '0;
            step_r    <= '0;
            id_r      <= '0;
            note_r    <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            presc_r   <= presc_s;
            tick_r    <= tick_s;
            dur_r     <= dur_s;
            step_r    <= step_s;
            id_r      <= id_s;
            note_r    <= note_s;
            done_r    <= done_s;
            busy_r    <= (state_s == ST_PLAY);
        end
    end

    assign note       = note_r;
    assign busy       = busy_r;
    assign active_id  = id_r;
    assign done_pulse = done_r;

endmodule
